// File: rtl/lcd_frame_sched.sv
// -----------------------------------------------------------------------------
// lcd_frame_sched
//
// Arbitrates two bitmap sources (0 = game board, 1 = score overlay) for the
// LCD. A granted source gets the whole frame: the scheduler asks the bitmap
// converter for FRAME_BYTES bytes one at a time. Each byte is forwarded to the
// LCD driver tagged with its page/column. Then the scheduler idles for
// GAP_CYCLES before it arbitrates again. Ties alternate between the sources,
// and source 0 wins the first tie after reset.
//
// Optional feature: define LCD_FRAME_SCHED_TIMEOUT_EN to abort a frame when
// the converter fails to answer a byte request within TMO_CYCLES. This sets
// the sticky err_o flag. Without the macro the scheduler waits indefinitely
// and err_o is tied low.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_i[1:0]     level update request per source, held until granted
//   gnt_o[1:0]     one-hot grant, held for the whole frame
//   src_sel_o      index of the granted source (converter table mux)
//   change_o       one-cycle pulse: converter must rebuild its bitmap
//   en_o           one-cycle byte request to the converter
//   data_valid_i   converter byte strobe, data_in_i[7:0] converter byte
//   lcd_ready_i    LCD driver accepts the presented byte
//   lcd_valid_o    byte presented, lcd_data_o/lcd_page_o/lcd_col_o its payload
//   frame_done_o   one-cycle pulse when the last byte of a frame is accepted
//   busy_o         scheduler is outside IDLE
//   err_o          sticky converter timeout flag
// -----------------------------------------------------------------------------
module lcd_frame_sched #(
    parameter int FRAME_BYTES = 512,
    parameter int GAP_CYCLES  = 16,
    parameter int TMO_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       src_sel_o,
    output logic       change_o,
    output logic       en_o,
    input  logic       data_valid_i,
    input  logic [7:0] data_in_i,
    input  logic       lcd_ready_i,
    output logic       lcd_valid_o,
    output logic [7:0] lcd_data_o,
    output logic [2:0] lcd_page_o,
    output logic [5:0] lcd_col_o,
    output logic       frame_done_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [8:0]    LAST_BYTE = 9'(FRAME_BYTES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ARB, START, REQB, WAITB, PUSH, GAP
    } state_t;

    state_t        state_q;
    logic [1:0]    gnt_q;
    logic          src_sel_q;
    logic          change_q;
    logic          en_q;
    logic          lcd_valid_q;
    logic [7:0]    lcd_data_q;
    logic [2:0]    lcd_page_q;
    logic [5:0]    lcd_col_q;
    logic          frame_done_q;
    logic          busy_q;
    logic [8:0]    byte_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    // Source that wins the next tie; flips to the other source on every grant.
    logic          prio_q;
    // Arbitration winner for the current request pattern.
    logic          win_d;

`ifdef LCD_FRAME_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          err_q;
`endif

    always_comb begin
        win_d = 1'b0;
        case (req_i)
            2'b01:   win_d = 1'b0;
            2'b10:   win_d = 1'b1;
            2'b11:   win_d = prio_q;
            default: win_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            src_sel_q    <= 1'b0;
            change_q     <= 1'b0;
            en_q         <= 1'b0;
            lcd_valid_q  <= 1'b0;
            lcd_data_q   <= 8'd0;
            lcd_page_q   <= 3'd0;
            lcd_col_q    <= 6'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            byte_cnt_q   <= 9'd0;
            gap_cnt_q    <= '0;
            prio_q       <= 1'b0;
`ifdef LCD_FRAME_SCHED_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-armed below.
            change_q     <= 1'b0;
            en_q         <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        state_q <= ARB;
                        busy_q  <= 1'b1;
                    end
                end

                ARB: begin
                    if (req_i == 2'b00) begin
                        // Requests are held until granted, so this only
                        // guards against a misbehaving requester.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gnt_q     <= win_d ? 2'b10 : 2'b01;
                        src_sel_q <= win_d;
                        prio_q    <= ~win_d;
                        change_q  <= 1'b1;  // high for the START cycle
                        state_q   <= START;
                    end
                end

                START: begin
                    byte_cnt_q <= 9'd0;
                    en_q       <= 1'b1;     // high for the REQB cycle
                    state_q    <= REQB;
                end

                REQB: begin
                    // en is only armed once the output buffer has drained,
                    // so exactly one byte is outstanding at the converter.
`ifdef LCD_FRAME_SCHED_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= WAITB;
                end

                WAITB: begin
                    if (data_valid_i) begin
                        lcd_data_q  <= data_in_i;
                        lcd_page_q  <= byte_cnt_q[8:6];
                        lcd_col_q   <= byte_cnt_q[5:0];
                        lcd_valid_q <= 1'b1;
                        state_q     <= PUSH;
                    end
`ifdef LCD_FRAME_SCHED_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        // Converter is stuck: drop the frame silently.
                        err_q     <= 1'b1;
                        gnt_q     <= 2'b00;
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end

                PUSH: begin
                    // Payload stays put until the driver takes it.
                    if (lcd_ready_i) begin
                        lcd_valid_q <= 1'b0;
                        if (byte_cnt_q == LAST_BYTE) begin
                            frame_done_q <= 1'b1;
                            gnt_q        <= 2'b00;
                            gap_cnt_q    <= '0;
                            state_q      <= GAP;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            en_q       <= 1'b1;
                            state_q    <= REQB;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign src_sel_o    = src_sel_q;
    assign change_o     = change_q;
    assign en_o         = en_q;
    assign lcd_valid_o  = lcd_valid_q;
    assign lcd_data_o   = lcd_data_q;
    assign lcd_page_o   = lcd_page_q;
    assign lcd_col_o    = lcd_col_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = busy_q;
`ifdef LCD_FRAME_SCHED_TIMEOUT_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_frame_sched.sv
module tb_lcd_frame_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_i = 2'b00;
    logic [1:0] gnt_o;
    logic       src_sel_o, change_o, en_o;
    logic       data_valid_i;
    logic [7:0] data_in_i;
    logic       lcd_ready_i = 1'b1;
    logic       lcd_valid_o;
    logic [7:0] lcd_data_o;
    logic [2:0] lcd_page_o;
    logic [5:0] lcd_col_o;
    logic       frame_done_o, busy_o, err_o;

    lcd_frame_sched dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o),
        .src_sel_o(src_sel_o), .change_o(change_o), .en_o(en_o),
        .data_valid_i(data_valid_i), .data_in_i(data_in_i),
        .lcd_ready_i(lcd_ready_i), .lcd_valid_o(lcd_valid_o),
        .lcd_data_o(lcd_data_o), .lcd_page_o(lcd_page_o), .lcd_col_o(lcd_col_o),
        .frame_done_o(frame_done_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Converter model: answers each en one cycle later with the byte index
    // since the last change pulse; conv_cut withholds answers from byte 5 on.
    logic conv_cut = 1'b0;
    int   conv_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid_i <= 1'b0;
            data_in_i    <= 8'd0;
            conv_idx     <= 0;
        end else begin
            data_valid_i <= 1'b0;
            if (change_o) conv_idx <= 0;
            else if (en_o) begin
                conv_idx <= conv_idx + 1;
                if (!(conv_cut && conv_idx >= 5)) begin
                    data_valid_i <= 1'b1;
                    data_in_i    <= 8'(conv_idx);
                end
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [25:0] pk(input logic [1:0] g, input logic s, input logic c,
                                       input logic e, input logic v, input logic [7:0] d,
                                       input logic [2:0] p, input logic [5:0] col,
                                       input logic fd, input logic b);
        return {g, s, c, e, v, d, p, col, fd, b, 1'b0};
    endfunction

    function automatic logic [25:0] outs();
        return {gnt_o, src_sel_o, change_o, en_o, lcd_valid_o, lcd_data_o,
                lcd_page_o, lcd_col_o, frame_done_o, busy_o, err_o};
    endfunction

    typedef struct {
        logic [1:0]  req;
        logic        rdy;
        logic [25:0] exp;
    } vec_t;
    vec_t tbl[14];

    // Watch a frame until frame_done; optionally stall the driver at one byte.
    task automatic watch_frame(input int first, input int stall_at,
                               output int got, output int bad, output int dones,
                               output int chgs, output int stall_bad,
                               output logic [8:0] stall_pc);
        logic       stalled;
        logic [7:0] sd;
        logic [2:0] sp;
        logic [5:0] sc;
        int         idx;
        got = 0; bad = 0; dones = 0; chgs = 0; stall_bad = 0; stall_pc = '0;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
            @(posedge clk); #1;
            if (change_o) chgs++;
            if (frame_done_o) dones++;
            else begin
                if (lcd_valid_o && !stalled && first + got == stall_at) begin
                    stalled = 1'b1;
                    sd = lcd_data_o; sp = lcd_page_o; sc = lcd_col_o;
                    stall_pc = {sp, sc};
                    if (sd != 8'(stall_at)) stall_bad++;
                    lcd_ready_i = 1'b0;
                    repeat (20) begin
                        @(posedge clk); #1;
                        if (!lcd_valid_o || en_o || lcd_data_o != sd ||
                            lcd_page_o != sp || lcd_col_o != sc) stall_bad++;
                    end
                    lcd_ready_i = 1'b1;
                end
                if (lcd_valid_o && lcd_ready_i) begin
                    idx = first + got;
                    if (lcd_data_o != 8'(idx) || lcd_page_o != 3'(idx >> 6) ||
                        lcd_col_o != 6'(idx)) bad++;
                    got++;
                end
            end
        end
        if (stall_at >= 0 && !stalled) stall_bad++;
    endtask

    // Count GAP cycles starting at the frame_done sample.
    task automatic gap_check(output int n, output int gb);
        n = 0; gb = 0;
        for (int k = 0; k < 64; k++) begin
            if (!busy_o) break;
            n++;
            if (gnt_o != 2'b00) gb++;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_grant(output logic [1:0] g, output logic c);
        g = 2'b00; c = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            if (gnt_o != 2'b00) begin
                g = gnt_o; c = change_o;
                break;
            end
        end
    endtask

    initial begin
        int got, bad, dones, chgs, sbad, nbusy, gbad, zbad, ndone;
        logic [8:0] spc;
        logic [1:0] g;
        logic       c;
        logic       found;

        // Frame start, one-cycle stall and mid-frame request drop, cycle by cycle.
        tbl[0]  = '{2'b00, 1'b1, pk(2'b00, 0, 0, 0, 0, 8'd0, 3'd0, 6'd0, 0, 0)};
        tbl[1]  = '{2'b00, 1'b1, pk(2'b00, 0, 0, 0, 0, 8'd0, 3'd0, 6'd0, 0, 0)};
        tbl[2]  = '{2'b01, 1'b1, pk(2'b00, 0, 0, 0, 0, 8'd0, 3'd0, 6'd0, 0, 1)};
        tbl[3]  = '{2'b01, 1'b1, pk(2'b01, 0, 1, 0, 0, 8'd0, 3'd0, 6'd0, 0, 1)};
        tbl[4]  = '{2'b01, 1'b1, pk(2'b01, 0, 0, 1, 0, 8'd0, 3'd0, 6'd0, 0, 1)};
        tbl[5]  = '{2'b01, 1'b1, pk(2'b01, 0, 0, 0, 0, 8'd0, 3'd0, 6'd0, 0, 1)};
        tbl[6]  = '{2'b01, 1'b0, pk(2'b01, 0, 0, 0, 1, 8'd0, 3'd0, 6'd0, 0, 1)};
        tbl[7]  = '{2'b01, 1'b0, pk(2'b01, 0, 0, 0, 1, 8'd0, 3'd0, 6'd0, 0, 1)};
        tbl[8]  = '{2'b01, 1'b1, pk(2'b01, 0, 0, 1, 0, 8'd0, 3'd0, 6'd0, 0, 1)};
        tbl[9]  = '{2'b01, 1'b1, pk(2'b01, 0, 0, 0, 0, 8'd0, 3'd0, 6'd0, 0, 1)};
        tbl[10] = '{2'b01, 1'b1, pk(2'b01, 0, 0, 0, 1, 8'd1, 3'd0, 6'd1, 0, 1)};
        tbl[11] = '{2'b00, 1'b1, pk(2'b01, 0, 0, 1, 0, 8'd1, 3'd0, 6'd1, 0, 1)};
        tbl[12] = '{2'b00, 1'b1, pk(2'b01, 0, 0, 0, 0, 8'd1, 3'd0, 6'd1, 0, 1)};
        tbl[13] = '{2'b00, 1'b1, pk(2'b01, 0, 0, 0, 1, 8'd2, 3'd0, 6'd2, 0, 1)};

        repeat (3) @(posedge clk);
        #1;
        chk("reset state", 32'(outs()), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            req_i = tbl[i].req;
            lcd_ready_i = tbl[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Rest of frame 1 (byte 2 is handed over at the next edge).
        watch_frame(3, -1, got, bad, dones, chgs, sbad, spc);
        chk("f1 bytes", got, 509);
        chk("f1 byte content", bad, 0);
        chk("f1 frame_done", dones, 1);
        chk("f1 extra change", chgs, 0);
        chk("f1 gnt at done", 32'(gnt_o), 0);
        req_i = 2'b11;
        gap_check(nbusy, gbad);
        chk("f1 gap cycles", nbusy, 16);
        chk("f1 gap gnt", gbad, 0);

        // Frame 2: tie goes to source 1; stall driver at byte 100.
        wait_grant(g, c);
        chk("f2 grant", 32'(g), 32'(2'b10));
        chk("f2 change", 32'(c), 1);
        chk("f2 src_sel", 32'(src_sel_o), 1);
        watch_frame(0, 100, got, bad, dones, chgs, sbad, spc);
        chk("f2 bytes", got, 512);
        chk("f2 byte content", bad, 0);
        chk("f2 frame_done", dones, 1);
        chk("f2 stall stable", sbad, 0);
        chk("f2 stall page/col", 32'(spc), 32'({3'd1, 6'd36}));
        gap_check(nbusy, gbad);
        chk("f2 gap cycles", nbusy, 16);

        // Frame 3: tie back to source 0.
        wait_grant(g, c);
        chk("f3 grant", 32'(g), 32'(2'b01));
        watch_frame(0, -1, got, bad, dones, chgs, sbad, spc);
        chk("f3 bytes", got, 512);
        chk("f3 frame_done", dones, 1);
        req_i = 2'b01;
        gap_check(nbusy, gbad);
        chk("f3 gap cycles", nbusy, 16);

        // Frame 4: reset at byte 300.
        wait_grant(g, c);
        chk("f4 grant", 32'(g), 32'(2'b01));
        found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (lcd_valid_o && lcd_page_o == 3'd4 && lcd_col_o == 6'd44) begin
                found = 1'b1;
                break;
            end
        end
        chk("f4 reached byte 300", 32'(found), 1);
        chk("f4 byte 300 data", 32'(lcd_data_o), 32'd44);
        rst_n = 1'b0;
        #1;
        chk("async reset", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        req_i = 2'b00;
        rst_n = 1'b1;
        zbad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (outs() != 26'd0) zbad++;
        end
        chk("quiet after reset", zbad, 0);
        req_i = 2'b01;
        wait_grant(g, c);
        chk("restart grant", 32'(g), 32'(2'b01));
        chk("restart change", 32'(c), 1);
        watch_frame(0, -1, got, bad, dones, chgs, sbad, spc);
        chk("restart bytes", got, 512);
        chk("restart content", bad, 0);
        chk("restart frame_done", dones, 1);

        // Tie right after reset goes to source 0; then the converter stalls.
        rst_n = 1'b0;
        #1;
        req_i = 2'b11;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_grant(g, c);
        chk("tie after reset", 32'(g), 32'(2'b01));
        conv_cut = 1'b1;
        req_i = 2'b00;
        ndone = 0;
        repeat (1100) begin
            @(posedge clk); #1;
            if (frame_done_o) ndone++;
        end
        chk("stuck no frame_done", ndone, 0);
`ifdef LCD_FRAME_SCHED_TIMEOUT_EN
        chk("timeout err", 32'(err_o), 1);
        chk("timeout gnt", 32'(gnt_o), 0);
        chk("timeout busy", 32'(busy_o), 0);
`else
        chk("stuck err", 32'(err_o), 0);
        chk("stuck busy", 32'(busy_o), 1);
        chk("stuck gnt", 32'(gnt_o), 32'(2'b01));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_frame_sched.md
LCD_FRAME_SCHED -- requirements
Module: lcd_frame_sched

Interface
REQ-001 Parameter FRAME_BYTES, 512, bytes per frame (8 pages x 64 columns).
REQ-002 Parameter GAP_CYCLES, 16, minimum idle cycles between frame end and next grant.
REQ-003 Parameter TMO_CYCLES, 1024, max cycles from en to data_valid before abort.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req  in  2  update request per source (0 = game board, 1 = score overlay), level, held until granted.
REQ-007 gnt  out  2  one-hot grant, held for the whole frame.
REQ-008 src_sel  out  1  index of granted source, drives table mux to the bitmap converter.
REQ-009 change  out  1  one-cycle pulse telling the converter to rebuild its bitmap.
REQ-010 en  out  1  one-cycle byte request to the converter.
REQ-011 data_valid  in  1  converter byte strobe; data_in  in  8  converter byte.
REQ-012 lcd_ready  in  1  LCD driver can accept a byte.
REQ-013 lcd_valid  out  1  byte present; lcd_data  out  8  byte; lcd_page  out  3  page; lcd_col  out  6  column.
REQ-014 frame_done  out  1  one-cycle pulse at frame completion; busy  out  1  high outside IDLE; err  out  1  sticky timeout flag.

Function
REQ-015 FSM states IDLE, ARB, START, REQB, WAITB, PUSH, GAP; reset state IDLE.
REQ-016 IDLE -> ARB when req != 0; otherwise remain.
REQ-017 ARB: one requester -> grant it; both -> grant the source not granted last (round-robin); pointer resets so source 0 wins first tie; gnt/src_sel register in ARB, next state START.
REQ-018 START: change pulses exactly one cycle, byte_cnt cleared to 0, next state REQB.
REQ-019 REQB: en pulses one cycle only when output buffer empty (lcd_valid low); next WAITB; at most one byte outstanding.
REQ-020 WAITB: on data_valid capture data_in into lcd_data, lcd_page = byte_cnt[8:6], lcd_col = byte_cnt[5:0], set lcd_valid, go PUSH; data_valid in any other state is ignored.
REQ-021 PUSH: lcd_valid and lcd_data/page/col held stable until lcd_ready high; on lcd_valid&&lcd_ready clear lcd_valid, increment byte_cnt; if byte_cnt was FRAME_BYTES-1 pulse frame_done and go GAP, else go REQB.
REQ-022 byte_cnt 9 bits, no wrap within a frame; page advances every 64 bytes.
REQ-023 GAP: gnt cleared on entry, gap counter counts GAP_CYCLES, then IDLE; requests arriving during GAP or any busy state wait, never pre-empt.
REQ-024 Request deasserted mid-frame: frame still completes; same-source request asserted mid-frame served after GAP (subject to round-robin).
REQ-025 Minimum frame latency req->first en = 3 cycles (IDLE, ARB, START).
REQ-026 busy = (state != IDLE).

Reset
REQ-027 rst_n low at any time, including mid-frame, immediately forces: state IDLE, gnt 0, src_sel 0, change 0, en 0, lcd_valid 0, lcd_data 0, lcd_page 0, lcd_col 0, frame_done 0, busy 0, err 0, counters 0, round-robin pointer favouring source 0.
REQ-028 After reset release no output changes until first clk edge with req != 0.

Configuration
REQ-029 Macro LCD_FRAME_SCHED_TIMEOUT_EN defined: WAITB counts cycles; reaching TMO_CYCLES without data_valid sets err (sticky until reset), aborts frame without frame_done, goes GAP.
REQ-030 Macro undefined: no timeout counter, WAITB waits indefinitely, err tied 0.

Verification
REQ-031 req=2'b01 held, lcd_ready=1, converter returns data_valid 1 cycle after en with data_in=byte index[7:0] -> gnt=01, single change pulse, 512 lcd_valid handshakes, page 0..7 / col 0..63 in order, one frame_done, then 16 GAP cycles.
REQ-032 req=2'b11 held for three frames -> grant order 01, 10, 01.
REQ-033 lcd_ready low for 20 cycles at byte 100 -> lcd_valid, lcd_data, page 1, col 36 stable for 20 cycles; no en issued during stall.
REQ-034 rst_n pulsed low at byte 300 -> all outputs 0 asynchronously; after release with req=01, frame restarts at page 0 col 0 with new change pulse.
REQ-035 With LCD_FRAME_SCHED_TIMEOUT_EN, data_valid withheld after byte 5's en -> err=1 after 1024 cycles, no frame_done, gnt cleared; without macro, busy stays 1 indefinitely, err=0.
